// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// Port 0 and port 1 are packed along the outer dimension of each vector.
interface alu_arbiter_if #(
  parameter int DW = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][2:0]    req_op;
  logic [1:0][DW-1:0] req_a;
  logic [1:0][DW-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic               rsp_zero;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional response timeout enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  alu_arbiter_if.slave  bus,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  output logic          timeout_flag
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_MOV = 3'd1, OP_XOR = 3'd2, OP_AND = 3'd3,
    OP_NA4 = 3'd4, OP_LSL = 3'd5, OP_CMP = 3'd6, OP_NA7 = 3'd7
  } op_mne_e;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be at least 1");
  end

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] data_q, data_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic [1:0]    grant;
  logic          win;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tflag_q, tflag_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;
    grant   = 2'b00;
    win     = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d   = '0;
    tflag_d = tflag_q;
`endif

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          // A tie goes to the port that did not win last time.
          win        = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
          grant[win] = 1'b1;
          win_d      = win;
          last_d     = win;
          if (bus.req_op[win] == OP_NA4 || bus.req_op[win] == OP_NA7) begin
            // Illegal opcodes never reach the ALU; its inputs keep their old values.
            err_d   = 1'b1;
            data_d  = '0;
            zero_d  = 1'b0;
            state_d = RESP;
          end else begin
            op_d    = bus.req_op[win];
            a_d     = bus.req_a[win];
            b_d     = bus.req_b[win];
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        data_d  = alu_out;
        zero_d  = alu_zero;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[win_q]) begin
          state_d = IDLE;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // req_ready is combinational in IDLE, so it must also be masked while reset is held.
  assign bus.req_ready = grant & {2{Reset_n}};
  assign bus.rsp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
  assign alu_op        = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (3-bit `op_mne` opcodes ADD, MOV, XOR, AND, NA4, LSL, CMP, NA7) between two requesters, e.g. the main datapath (port 0) and the address/branch unit (port 1). Each request is a valid/ready handshake carrying an opcode and two operands. The block arbitrates round-robin, latches the winning command, drives the ALU for one cycle, and returns the registered result to the winning requester through a valid/ready response channel. Unused opcodes NA4 and NA7 are rejected with an error response and never reach the ALU.

## Interface
Parameters:
- `DW`, 8, operand/result width.
- `TIMEOUT`, 16, response-hold cycles before forced drop (only with `ALU_ARB_TIMEOUT_EN`).

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_op`  in  2x3  per-requester opcode (`op_mne`).
- `req_a`, `req_b`  in  2xDW  per-requester operands.
- `rsp_valid`  out  2  one-hot response valid to the granted requester.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_data`  out  DW  registered ALU result (shared by both ports).
- `rsp_zero`  out  1  registered ALU zero flag.
- `rsp_err`  out  1  high with `rsp_valid` when the opcode was NA4/NA7.
- `alu_op`  out  3  opcode to ALU.
- `alu_a`, `alu_b`  out  DW  operands to ALU.
- `alu_out`  in  DW  ALU result (combinational).
- `alu_zero`  in  1  ALU zero flag (combinational).
- `timeout_flag`  out  1  sticky; set when a response is dropped (0 without macro).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, pick winner: only-one-valid wins; both valid → the port not granted last. `req_ready[winner]`=1 combinationally this cycle; handshake latches op, a, b, winner index, updates last-granted pointer.
  - Legal op → EXEC. NA4/NA7 → RESP with err=1, data=0, zero=0.
- EXEC: `alu_op/alu_a/alu_b` driven from latches; at end of cycle capture `alu_out`→`rsp_data`, `alu_zero`→`rsp_zero`, err=0 → RESP.
- RESP: `rsp_valid[winner]`=1 and data/zero/err held stable until `rsp_ready[winner]`; on handshake → IDLE. `rsp_ready` of the other port ignored.
- `req_ready` is 0 in EXEC and RESP; no new request accepted until response handshake completes.
- Outside EXEC, `alu_op/alu_a/alu_b` hold last latched values (no glitch requirement beyond that).
- CMP and MOV are treated as any legal op; result passed through unmodified.
- Reset (any state, any time): state=IDLE, last-granted=1 (port 0 wins first tie), all latches, `rsp_data`, `rsp_zero`, `rsp_err`, `alu_op/a/b`=0, `rsp_valid`=0, `req_ready`=0 while `Reset_n` low, `timeout_flag`=0. In-flight command discarded, no response.

## Timing
- Request handshake in cycle N → EXEC in N+1 → `rsp_valid` from N+2. Illegal op: `rsp_valid` from N+1.
- Response handshake in cycle M → IDLE in M+1 → earliest next `req_ready` in M+1. Minimum throughput one op per 3 cycles.
- `req_ready` depends combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined: a counter starts at RESP entry; if no response handshake after `TIMEOUT` cycles in RESP, `rsp_valid` drops, FSM → IDLE, `timeout_flag` set (sticky until reset). Counter width `$clog2(TIMEOUT+1)`.
- Not defined: RESP waits indefinitely; no counter; `timeout_flag` tied 0.

## Test plan
- Reset then port 0 only: ADD a=8'h12 b=8'h34 → `req_ready`=2'b01 same cycle, `rsp_valid`=2'b01 two cycles later, `rsp_data`=8'h46, zero=0, err=0.
- Both ports valid every cycle, port 0 XOR 8'hFF/8'hFF, port 1 AND 8'hF0/8'h0F → grants alternate 0,1,0,1; each response data=0, zero=1.
- Port 1 issues opcode NA7 → `rsp_valid`=2'b10 next cycle, err=1, data=0; `alu_op` unchanged from previous value.
- Port 0 LSL, hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, data stable 5 cycles, `req_ready`=0 throughout despite port 1 valid; port 1 granted cycle after handshake.
- Assert `Reset_n`=0 during EXEC → outputs zero asynchronously, no response issued; after release port 0 wins a tie.
- With `ALU_ARB_TIMEOUT_EN`, TIMEOUT=16, `rsp_ready`=0 → `rsp_valid` drops after 16 RESP cycles, `timeout_flag`=1 and stays 1; next request served normally.
